qtcore_run_controller: RTL
==========================

Name: qtcore_run_controller

Overview:
- Host-side sequencer for the qtcore processor.
- Owns the processor's scan chain and its processor_enable line; the two are never active in the same cycle.
- Executes four host commands:
  - LOAD: shift a byte stream into the chain.
  - RUN: enable the processor until it halts or hits a cycle limit.
  - STEP: enable the processor for exactly one cycle.
  - UNLOAD: read the chain back out non-destructively.
- Sits between the chip IO wrapper and the core.

Parameters:
- SCAN_LEN, 64: number of flops in the core scan chain (≥1). NBYTES = ceil(SCAN_LEN/8).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (0 = reset).
- cmd_valid  in  1  command handshake valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 LOAD, 01 RUN, 10 UNLOAD, 11 STEP.
- run_limit  in  16  RUN cycle cap, sampled at RUN acceptance; 0 = unlimited.
- din_valid  in  1  load byte valid.
- din_ready  out  1  load byte ready.
- din  in  8  load byte.
- dout_valid  out  1  unload byte valid.
- dout_ready  in  1  unload byte ready.
- dout  out  8  unload byte.
- scan_enable  out  1  to core scan_enable.
- scan_in  out  1  to core scan_in.
- scan_out  in  1  from core scan_out.
- processor_enable  out  1  to core.
- processor_halted  in  1  from core; only meaningful while processor_enable=1.
- busy  out  1  state != IDLE.
- halted_seen  out  1  sticky; cleared when RUN/STEP is accepted.
- timeout  out  1  sticky; cleared when RUN/STEP is accepted.
- run_cycles  out  16  enabled cycles in the last RUN/STEP; saturates at 0xFFFF.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state = IDLE.
  - All outputs 0, except cmd_ready = 1.
  - Counters and flags cleared.
  - Mid-operation reset aborts immediately; chain contents become undefined.
- Command acceptance:
  - A command is accepted on cmd_valid & cmd_ready.
  - Acceptance moves the FSM out of IDLE on the next edge.
  - cmd_op is not looked at outside IDLE.
- States: IDLE, LD_WAIT, LD_SHIFT, RUN, STEP, UL_SHIFT, UL_OUT.
- LOAD:
  - LD_WAIT: din_ready = 1. On din_valid, latch din and go to LD_SHIFT.
  - LD_SHIFT: scan_enable = 1 and scan_in = byte[k], LSB first, one bit per cycle.
  - Every byte except the last shifts 8 bits.
  - The last byte shifts SCAN_LEN − 8·(NBYTES−1) bits; its unused upper bits are ignored.
  - After each byte, return to LD_WAIT until NBYTES bytes are consumed, then go to IDLE.
  - Total shift cycles = SCAN_LEN exactly.
  - Result: the first bit supplied sits next to scan_out.
  - din_ready = 0 in every state except LD_WAIT.
- UNLOAD:
  - UL_SHIFT: scan_enable = 1 and scan_in = scan_out (recirculate). Each cycle captures scan_out into dout bit k, LSB first.
  - After 8 bits, or the remaining bits for the last byte, go to UL_OUT.
  - Upper bits of a partial last byte read 0.
  - UL_OUT: dout_valid = 1, dout held stable until dout_ready. Then continue shifting, or go to IDLE after NBYTES bytes.
  - After exactly SCAN_LEN recirculating shifts the chain contents equal their pre-UNLOAD values.
  - Bytes come out in the same order and packing as LOAD.
- RUN:
  - processor_enable = 1 every cycle in RUN; run_cycles increments each such cycle.
  - If processor_halted = 1 is sampled, set halted_seen and go to IDLE. processor_enable is 0 from the next cycle.
  - Else, if run_limit != 0 and run_cycles + 1 == run_limit, set timeout and go to IDLE. Exactly run_limit enabled cycles occur.
  - If halt and limit coincide in the same cycle, halt wins: halted_seen = 1, timeout = 0.
- STEP:
  - Exactly one cycle with processor_enable = 1; run_cycles = 1.
  - halted_seen is set if processor_halted = 1 in that cycle. Return to IDLE.
- Global invariants:
  - scan_enable and processor_enable are never both 1.
  - Both are 0 in IDLE, LD_WAIT and UL_OUT.
  - All outputs are registered or decoded from state only; there is no combinational path from din or cmd to scan_in.

Test Plan:
- SCAN_LEN=12, LOAD bytes 0xA5, 0x03 → 12 scan_enable cycles; scan_in sequence 1,0,1,0,0,1,0,1,1,1,0,0; din_ready low during shifting; busy low afterwards.
- Same chain, UNLOAD right after that LOAD → dout 0xA5 then 0x03. A second UNLOAD returns identical bytes, proving the recirculation is non-destructive. Holding dout_ready = 0 for 5 cycles keeps dout and the chain frozen.
- RUN with run_limit = 0 and processor_halted rising on enabled cycle 7 → run_cycles = 7, halted_seen = 1, timeout = 0, processor_enable low from the next cycle.
- RUN with run_limit = 4 and no halt → exactly 4 enabled cycles, timeout = 1, run_cycles = 4. A following STEP clears the flags and gives run_cycles = 1.
- run_limit = 3 with halt on cycle 3 → halted_seen = 1, timeout = 0.
- Drive rst = 0 during the 5th LD_SHIFT cycle → next cycle state is IDLE, scan_enable = 0, cmd_ready = 1. A new LOAD then completes normally.

Source files
------------

// File: rtl/qtcore_run_controller.sv
// qtcore_run_controller
// Host-side sequencer for the qtcore processor. It owns the core scan chain
// and the processor_enable line, and never drives both in the same cycle.
// Host commands: LOAD (bytes into the chain), RUN (enable until halt or
// cycle cap), STEP (one enabled cycle), UNLOAD (non-destructive readback).
//
// Ports
//   i_clk, i_rst          clock, synchronous active-low reset (0 = reset)
//   i_cmd_valid/o_cmd_ready, i_cmd_op[1:0]   command handshake
//                         (00 LOAD, 01 RUN, 10 UNLOAD, 11 STEP)
//   i_run_limit[15:0]     RUN cycle cap, 0 = unlimited, sampled at accept
//   i_din_valid/o_din_ready, i_din[7:0]      LOAD byte stream
//   o_dout_valid/i_dout_ready, o_dout[7:0]   UNLOAD byte stream
//   o_scan_enable, o_scan_in, i_scan_out     core scan chain
//   o_processor_enable, i_processor_halted   core run control
//   o_busy, o_halted_seen, o_timeout, o_run_cycles[15:0]  status
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a command, cmd_ready = 1
// LD_WAIT   | waiting for the next load byte, din_ready = 1
// LD_SHIFT  | shifting the latched load byte into the chain, LSB first
// RUN       | processor enabled until halt or cycle cap
// STEP      | processor enabled for exactly one cycle
// UL_SHIFT  | recirculating the chain, capturing scan_out into dout
// UL_OUT    | presenting a captured byte until dout_ready

module qtcore_run_controller #(
    parameter int SCAN_LEN = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [15:0] i_run_limit,
    input  logic        i_din_valid,
    output logic        o_din_ready,
    input  logic [7:0]  i_din,
    output logic        o_dout_valid,
    input  logic        i_dout_ready,
    output logic [7:0]  o_dout,
    output logic        o_scan_enable,
    output logic        o_scan_in,
    input  logic        i_scan_out,
    output logic        o_processor_enable,
    input  logic        i_processor_halted,
    output logic        o_busy,
    output logic        o_halted_seen,
    output logic        o_timeout,
    output logic [15:0] o_run_cycles
);

    localparam int NBYTES    = (SCAN_LEN + 7) / 8;
    localparam int LAST_BITS = SCAN_LEN - 8 * (NBYTES - 1);
    localparam int BCW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [2:0]     LAST_IDX  = 3'(LAST_BITS - 1);
    localparam logic [2:0]     FIRST_IDX = (NBYTES == 1) ? LAST_IDX : 3'd7;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_RUN    = 2'b01;
    localparam logic [1:0] OP_UNLOAD = 2'b10;
    localparam logic [1:0] OP_STEP   = 2'b11;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LD_WAIT  = 3'd1;
    localparam logic [2:0] S_LD_SHIFT = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_STEP     = 3'd4;
    localparam logic [2:0] S_UL_SHIFT = 3'd5;
    localparam logic [2:0] S_UL_OUT   = 3'd6;

    logic [2:0]     r_state;
    logic [BCW-1:0] r_byte_cnt;
    logic [2:0]     r_bit_cnt;      // bits left in current byte, minus one
    logic [7:0]     r_shreg;
    logic [7:0]     r_dout;
    logic [15:0]    r_run_limit;
    logic [15:0]    r_run_cycles;
    logic           r_halted_seen;
    logic           r_timeout;

    logic [BCW-1:0] w_byte_nxt;
    logic [2:0]     w_last_idx;
    logic [2:0]     w_next_idx;
    logic [2:0]     w_pos;
    logic [16:0]    w_cycles_inc;
    logic [15:0]    w_cycles_sat;
    logic           w_limit_hit;

    assign w_byte_nxt = r_byte_cnt + BCW'(1);
    assign w_last_idx = (r_byte_cnt == LAST_BYTE) ? LAST_IDX : 3'd7;
    assign w_next_idx = (w_byte_nxt == LAST_BYTE) ? LAST_IDX : 3'd7;
    // Bit counter runs down, so the capture position counts up from 0.
    assign w_pos      = w_last_idx - r_bit_cnt;

    assign w_cycles_inc = {1'b0, r_run_cycles} + 17'd1;
    assign w_cycles_sat = w_cycles_inc[16] ? 16'hFFFF : w_cycles_inc[15:0];
    assign w_limit_hit  = (r_run_limit != 16'd0) &&
                          (w_cycles_inc == {1'b0, r_run_limit});

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= S_IDLE;
            r_byte_cnt    <= '0;
            r_bit_cnt     <= 3'd0;
            r_shreg       <= 8'd0;
            r_dout        <= 8'd0;
            r_run_limit   <= 16'd0;
            r_run_cycles  <= 16'd0;
            r_halted_seen <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_byte_cnt <= '0;
                        case (i_cmd_op)
                            OP_LOAD: r_state <= S_LD_WAIT;
                            OP_UNLOAD: begin
                                r_bit_cnt <= FIRST_IDX;
                                r_dout    <= 8'd0;
                                r_state   <= S_UL_SHIFT;
                            end
                            OP_RUN, OP_STEP: begin
                                r_run_limit   <= i_run_limit;
                                r_run_cycles  <= 16'd0;
                                r_halted_seen <= 1'b0;
                                r_timeout     <= 1'b0;
                                r_state       <= (i_cmd_op == OP_RUN) ? S_RUN : S_STEP;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_LD_WAIT: begin
                    if (i_din_valid) begin
                        r_shreg   <= i_din;
                        r_bit_cnt <= w_last_idx;
                        r_state   <= S_LD_SHIFT;
                    end
                end
                S_LD_SHIFT: begin
                    r_shreg <= {1'b0, r_shreg[7:1]};
                    if (r_bit_cnt == 3'd0) begin
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_byte_cnt <= w_byte_nxt;
                            r_state    <= S_LD_WAIT;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                    end
                end
                S_RUN: begin
                    r_run_cycles <= w_cycles_sat;
                    // Halt takes priority over a coincident cycle cap.
                    if (i_processor_halted) begin
                        r_halted_seen <= 1'b1;
                        r_state       <= S_IDLE;
                    end else if (w_limit_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_STEP: begin
                    r_run_cycles  <= 16'd1;
                    r_halted_seen <= i_processor_halted;
                    r_state       <= S_IDLE;
                end
                S_UL_SHIFT: begin
                    r_dout[w_pos] <= i_scan_out;
                    if (r_bit_cnt == 3'd0) begin
                        r_state <= S_UL_OUT;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                    end
                end
                S_UL_OUT: begin
                    if (i_dout_ready) begin
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_byte_cnt <= w_byte_nxt;
                            r_bit_cnt  <= w_next_idx;
                            r_dout     <= 8'd0;
                            r_state    <= S_UL_SHIFT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready        = (r_state == S_IDLE);
    assign o_busy             = (r_state != S_IDLE);
    assign o_din_ready        = (r_state == S_LD_WAIT);
    assign o_dout_valid       = (r_state == S_UL_OUT);
    assign o_dout             = r_dout;
    assign o_scan_enable      = (r_state == S_LD_SHIFT) || (r_state == S_UL_SHIFT);
    assign o_scan_in          = (r_state == S_LD_SHIFT) ? r_shreg[0] :
                                (r_state == S_UL_SHIFT) ? i_scan_out : 1'b0;
    assign o_processor_enable = (r_state == S_RUN) || (r_state == S_STEP);
    assign o_halted_seen      = r_halted_seen;
    assign o_timeout          = r_timeout;
    assign o_run_cycles       = r_run_cycles;

endmodule
